// File: rtl/pipe_pkg.sv
// Shared constants for the arithmetic pipeline's read side: op encodings,
// default widths and data memory depth.
package pipe_pkg;

    localparam int unsigned AW_DEF    = 8;
    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned RW_DEF    = 4;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned MEM_DEPTH = 1 << AW_DEF;

    localparam logic [OP_W-1:0] OP_PASS = 2'd0;
    localparam logic [OP_W-1:0] OP_NEG  = 2'd1;
    localparam logic [OP_W-1:0] OP_HI   = 2'd2;
    localparam logic [OP_W-1:0] OP_LO   = 2'd3;

endpackage

// File: rtl/pipe_dmem.sv
// Data memory: one write port and one registered read port with read enable.
// The array is not reset; a same-edge write is not seen by the read.
module pipe_dmem #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pipe_mem_reader.sv
// 3-stage read pipeline over the pipeline's data memory with result formatting.
// Define PIPE_MEM_READER_FWD_EN to forward a same-edge write into the S2 read.
module pipe_mem_reader
    import pipe_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [RW-1:0]   req_rd,
    input  logic [OP_W-1:0] req_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [RW-1:0]   rsp_rd,
    output logic [AW-1:0]   rsp_addr,
    output logic [15:0]     done_cnt
);

    logic            adv;
    logic            s1_valid;
    logic [AW-1:0]   s1_addr;
    logic [RW-1:0]   s1_rd;
    logic [OP_W-1:0] s1_op;
    logic            s2_valid;
    logic [AW-1:0]   s2_addr;
    logic [RW-1:0]   s2_rd;
    logic [OP_W-1:0] s2_op;
    logic [DW-1:0]   mem_q;
    logic [DW-1:0]   s2_data;
    logic [DW-1:0]   fmt_data;

    // Whole pipe freezes while the held response is refused.
    assign adv       = !(rsp_valid && !rsp_ready);
    assign req_ready = adv;

    pipe_dmem #(.AW(AW), .DW(DW)) u_dmem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (adv),
        .rd_addr (s1_addr),
        .rd_data (mem_q)
    );

`ifdef PIPE_MEM_READER_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (adv) begin
            fwd_hit  <= wr_en && (wr_addr == s1_addr);
            fwd_data <= wr_data;
        end
    end

    assign s2_data = fwd_hit ? fwd_data : mem_q;
`else
    assign s2_data = mem_q;
`endif

    // Payload registers load only behind a valid bit so bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_rd     <= '0;
            s1_op     <= OP_PASS;
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_rd     <= '0;
            s2_op     <= OP_PASS;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_addr  <= '0;
        end else if (adv) begin
            s1_valid  <= req_valid;
            s2_valid  <= s1_valid;
            rsp_valid <= s2_valid;
            if (req_valid) begin
                s1_addr <= req_addr;
                s1_rd   <= req_rd;
                s1_op   <= req_op;
            end
            if (s1_valid) begin
                s2_addr <= s1_addr;
                s2_rd   <= s1_rd;
                s2_op   <= s1_op;
            end
            if (s2_valid) begin
                rsp_data <= fmt_data;
                rsp_rd   <= s2_rd;
                rsp_addr <= s2_addr;
            end
        end
    end

    // Result formatting, all arithmetic modulo 2^DW.
    always_comb begin
        fmt_data = s2_data;
        case (s2_op)
            OP_PASS: fmt_data = s2_data;
            OP_NEG:  fmt_data = (~s2_data) + DW'(1);
            OP_HI:   fmt_data = DW'(s2_data[DW-1:DW/2]);
            OP_LO:   fmt_data = {{(DW/2){s2_data[DW/2-1]}}, s2_data[DW/2-1:0]};
            default: fmt_data = s2_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_mem_reader.sv
// Scoreboard bench for pipe_mem_reader: requests push expected responses,
// a negedge monitor pops and compares on every completed handshake.
module tb_pipe_mem_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [3:0]  req_rd;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_rd;
    logic [7:0]  rsp_addr;
    logic [15:0] done_cnt;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  rd;
        logic [7:0]  addr;
        int          lat_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pipe_mem_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_rd    (req_rd),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd),
        .rsp_addr  (rsp_addr),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {16'h0, rsp_data}, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
                    chk("rsp_rd",   {28'h0, rsp_rd},   {28'h0, e.rd});
                    chk("rsp_addr", {24'h0, rsp_addr}, {24'h0, e.addr});
                    if (e.lat_cyc >= 0) begin
                        chk("rsp_latency", 32'(cyc), 32'(e.lat_cyc));
                    end
                end
            end
        end
    end

    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Leaves req_valid high so consecutive calls stream back-to-back.
    task automatic issue(input logic [7:0] a, input logic [3:0] rd, input logic [1:0] op,
                         input logic [15:0] exp_data, input bit chk_lat);
        exp_t e;
        bit   ok;
        req_valid = 1'b1; req_addr = a; req_rd = rd; req_op = op;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) chk("req_accept_timeout", 32'(req_ready), 32'd1);
        e.data = exp_data; e.rd = rd; e.addr = a;
        e.lat_cyc = chk_lat ? cyc + 3 : -1;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; req_rd = '0; req_op = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_done_cnt",  {16'h0, done_cnt}, 32'h0);
        chk("reset_rsp_data",  {16'h0, rsp_data}, 32'h0);
        @(posedge clk); #1;

        // Streaming reads with latency check and tag echo.
        mem_write(8'd125, 16'h0008);
        mem_write(8'd126, 16'h0002);
        mem_write(8'd127, 16'h000C);
        issue(8'd125, 4'd1, 2'd0, 16'h0008, 1'b1);
        issue(8'd126, 4'd2, 2'd0, 16'h0002, 1'b1);
        issue(8'd127, 4'd3, 2'd0, 16'h000C, 1'b1);
        idle_req();
        drain();
        chk("done_cnt_after_stream", {16'h0, done_cnt}, 32'd3);

        // Format ops, including negate of zero.
        mem_write(8'd10, 16'h80F3);
        mem_write(8'd11, 16'h0000);
        mem_write(8'd0,  16'h8000);
        mem_write(8'd255, 16'h7F80);
        issue(8'd10, 4'd4, 2'd1, 16'h7F0D, 1'b0);
        issue(8'd10, 4'd5, 2'd2, 16'h0080, 1'b0);
        issue(8'd10, 4'd6, 2'd3, 16'hFFF3, 1'b0);
        issue(8'd11, 4'd7, 2'd1, 16'h0000, 1'b0);
        issue(8'd0,  4'd8, 2'd1, 16'h8000, 1'b0);
        issue(8'd255, 4'd9, 2'd3, 16'hFF80, 1'b0);
        issue(8'd255, 4'd10, 2'd2, 16'h007F, 1'b0);
        idle_req();
        drain();

        // Backpressure: responses held stable and intake blocked.
        issue(8'd125, 4'd11, 2'd0, 16'h0008, 1'b0);
        issue(8'd126, 4'd12, 2'd0, 16'h0002, 1'b0);
        issue(8'd127, 4'd13, 2'd0, 16'h000C, 1'b0);
        idle_req();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data",  {16'h0, rsp_data}, 32'h0008);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();
        chk("done_cnt_after_stall", {16'h0, done_cnt}, 32'd13);

        // Same-edge write while the read moves from S1 to S2.
        mem_write(8'd200, 16'h1111);
        req_valid = 1'b1; req_addr = 8'd200; req_rd = 4'd14; req_op = 2'd0;
        @(negedge clk);
        chk("fwd_req_ready", 32'(req_ready), 32'd1);
`ifdef PIPE_MEM_READER_FWD_EN
        exp_q.push_back('{data: 16'h2222, rd: 4'd14, addr: 8'd200, lat_cyc: -1});
`else
        exp_q.push_back('{data: 16'h1111, rd: 4'd14, addr: 8'd200, lat_cyc: -1});
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_write(8'd200, 16'h2222);
        drain();
        issue(8'd200, 4'd15, 2'd0, 16'h2222, 1'b0);
        idle_req();
        drain();

        // Back-to-back writes to one address: last write wins.
        wr_en = 1'b1; wr_addr = 8'd201; wr_data = 16'h3333;
        @(posedge clk); #1;
        wr_data = 16'h4444;
        @(posedge clk); #1;
        wr_en = 1'b0;
        issue(8'd201, 4'd1, 2'd0, 16'h4444, 1'b0);
        idle_req();
        drain();

        // Reset with two requests in flight: nothing may come out.
        issue(8'd125, 4'd2, 2'd0, 16'h0008, 1'b0);
        issue(8'd126, 4'd3, 2'd0, 16'h0002, 1'b0);
        idle_req();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  {16'h0, rsp_data}, 32'h0);
        chk("rst_rsp_rd",    {28'h0, rsp_rd}, 32'h0);
        chk("rst_rsp_addr",  {24'h0, rsp_addr}, 32'h0);
        chk("rst_done_cnt",  {16'h0, done_cnt}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(8'd125, 4'd4, 2'd0, 16'h0008, 1'b0);
        issue(8'd10,  4'd5, 2'd0, 16'h80F3, 1'b0);
        idle_req();
        drain();

        // Counter wrap from 0xFFFF.
        force dut.done_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.done_cnt;
        @(posedge clk); #1;
        chk("cnt_preset", {16'h0, done_cnt}, 32'hFFFF);
        issue(8'd127, 4'd6, 2'd0, 16'h000C, 1'b0);
        idle_req();
        drain();
        chk("cnt_wrap", {16'h0, done_cnt}, 32'h0000);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
